// File: rtl/hit_judge_pkg.sv
// hit_judge_pkg: shared note width and judge FSM encoding for chart, judge and HUD stages
package hit_judge_pkg;
  localparam int NOTE_W = 5;
  typedef enum logic [1:0] {IDLE, ARMED, OPEN, DONE} state_t;
endpackage

// File: rtl/hit_judge_input.sv
// input_sync: 2-flop synchronizer with rising-edge detect on the synchronized value
module input_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);
  logic [W-1:0] s1, s2, s3;
  // two metastability flops plus one history flop for the edge detector
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign q = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/hit_judge.sv
// hit_judge: judges strummed fret chords against the chart and keeps score, streak and multiplier
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int CAPTURE_LAG   = 2,
  parameter int WINDOW_CYCLES = 6750000,
  parameter int POINTS        = 10,
  parameter int STREAK_STEP   = 8,
  parameter int MAX_MULT      = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              eight_beat,
  input  logic [NOTE_W-1:0] exp_notes,
  input  logic [NOTE_W-1:0] frets,
  input  logic              strum,
  output logic              hit,
  output logic              miss,
  output logic [15:0]       score,
  output logic [7:0]        streak,
  output logic [2:0]        mult,
  output logic [NOTE_W-1:0] cur_chord
);
  localparam int LW = CAPTURE_LAG < 2 ? 1 : $clog2(CAPTURE_LAG + 1);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  state_t state, state_n;
  logic [LW-1:0] lag, lag_n;
  logic [WW-1:0] win, win_n;
  logic [NOTE_W-1:0] chord, chord_n, frets_sync, fret_rise_unused;
  logic strum_evt, strum_sync_unused, hit_n, miss_n;
  logic [16:0] sum;
  logic [2:0] mult_n;
  input_sync #(.W(1)) u_strum (
    .clk(clk), .resetn(resetn), .d(strum), .q(strum_sync_unused), .rise(strum_evt)
  );
  input_sync #(.W(NOTE_W)) u_frets (
    .clk(clk), .resetn(resetn), .d(frets), .q(frets_sync), .rise(fret_rise_unused)
  );
  // next state and judgement; a beat overrides every state and restarts the capture lag
  always_comb begin
    state_n = state;
    lag_n = lag;
    win_n = win;
    chord_n = chord;
    hit_n = 1'b0;
    miss_n = 1'b0;
    if (state == OPEN) begin
      win_n = win - WW'(1);
      if (strum_evt) begin
        hit_n = frets_sync == chord;
        miss_n = frets_sync != chord;
        state_n = DONE;
      end else if (eight_beat) miss_n = 1'b1;
      else if (win <= WW'(1)) begin
        miss_n = 1'b1;
        state_n = DONE;
      end
    end else miss_n = strum_evt;
    if (state == ARMED) begin
      lag_n = lag - LW'(1);
      if (lag <= LW'(1)) begin
        chord_n = exp_notes;
        win_n = WW'(WINDOW_CYCLES);
        state_n = exp_notes != '0 ? OPEN : IDLE;
      end
    end
    if (eight_beat) begin
      state_n = ARMED;
      lag_n = LW'(CAPTURE_LAG);
    end
  end
  // saturating score sum and multiplier derived from the current streak
  always_comb begin
    sum = 17'(score) + 17'(POINTS * int'(mult));
    mult_n = 3'((1 + int'(streak) / STREAK_STEP) > MAX_MULT ? MAX_MULT : 1 + int'(streak) / STREAK_STEP);
  end
  // state, counters, pulses and scoring registers; mult trails streak by one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      lag <= '0;
      win <= '0;
      chord <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
      score <= '0;
      streak <= '0;
      mult <= 3'd1;
    end else begin
      state <= state_n;
      lag <= lag_n;
      win <= win_n;
      chord <= chord_n;
      hit <= hit_n;
      miss <= miss_n;
      score <= hit_n ? (sum[16] ? 16'hFFFF : sum[15:0]) : score;
      streak <= miss_n ? 8'd0 : hit_n ? (&streak ? streak : streak + 8'd1) : streak;
      mult <= mult_n;
    end
  end
  assign cur_chord = state == OPEN ? chord : '0;
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed and randomized checks of hit_judge against a timeline-based reference model
module tb_hit_judge;
  localparam int LAG = 2, WIN = 20, PTS = 10, STEP = 2, MAXM = 4;
  logic clk = 1'b0, resetn = 1'b0, eight_beat = 1'b0, strum = 1'b0;
  logic [4:0] exp_notes = '0, frets = '0;
  logic hit, miss;
  logic [15:0] score;
  logic [7:0] streak;
  logic [2:0] mult;
  logic [4:0] cur_chord;
  int n_tests = 0, n_fail = 0;
  hit_judge #(
    .CAPTURE_LAG(LAG), .WINDOW_CYCLES(WIN), .POINTS(PTS), .STREAK_STEP(STEP), .MAX_MULT(MAXM)
  ) dut (
    .clk(clk), .resetn(resetn), .eight_beat(eight_beat), .exp_notes(exp_notes), .frets(frets),
    .strum(strum), .hit(hit), .miss(miss), .score(score), .streak(streak), .mult(mult),
    .cur_chord(cur_chord)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction
  int cyc = 0, cap_at = -1, deadline = 0;
  bit open = 1'b0, m_hit = 1'b0, m_miss = 1'b0;
  logic [4:0] m_chord = '0;
  int m_score = 0, m_streak = 0, m_mult = 1;
  bit [2:0] st_h = '0;
  logic [4:0] fh [3] = '{default: '0};
  // reference timeline: capture LAG edges after a beat, expiry WIN edges after capture,
  // strum seen as a rising edge two edges after it is sampled raw
  always @(posedge clk or negedge resetn) begin : model
    bit ev;
    logic [4:0] fs;
    if (!resetn) begin
      cap_at = -1; open = 0; m_hit = 0; m_miss = 0; m_chord = '0;
      m_score = 0; m_streak = 0; m_mult = 1; st_h = '0; fh = '{default: '0};
    end else begin
      ev = st_h[1] & ~st_h[2];
      fs = fh[1];
      m_hit = 0;
      m_miss = 0;
      if (open) begin
        if (ev) begin
          m_hit = fs == m_chord;
          m_miss = !m_hit;
          open = 0;
        end else if (eight_beat) m_miss = 1;
        else if (cyc == deadline) begin
          m_miss = 1;
          open = 0;
        end
      end else m_miss = ev;
      if (eight_beat) begin
        cap_at = cyc + LAG;
        open = 0;
      end else if (cyc == cap_at) begin
        cap_at = -1;
        m_chord = exp_notes;
        open = exp_notes != 0;
        deadline = cyc + WIN;
      end
      if (m_hit) m_score = imin(m_score + PTS * m_mult, 65535);
      m_mult = imin(1 + m_streak / STEP, MAXM);
      m_streak = m_miss ? 0 : m_hit ? imin(m_streak + 1, 255) : m_streak;
      st_h = {st_h[1:0], strum};
      fh[2] = fh[1];
      fh[1] = fh[0];
      fh[0] = frets;
      cyc++;
    end
  end
  // every cycle out of reset, all outputs are compared to the model
  always @(negedge clk) begin
    if (resetn) begin
      chk("hit", hit, m_hit);
      chk("miss", miss, m_miss);
      chk("score", score, m_score);
      chk("streak", streak, m_streak);
      chk("mult", mult, m_mult);
      chk("cur_chord", cur_chord, open ? m_chord : 5'd0);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic beat(input logic [4:0] c, input logic [4:0] f);
    eight_beat = 1'b1;
    exp_notes = c;
    frets = f;
    @(negedge clk);
    eight_beat = 1'b0;
  endtask
  task automatic strum_pulse();
    strum = 1'b1;
    tick(2);
    strum = 1'b0;
  endtask
  task automatic hit_seq(input logic [4:0] c);
    beat(c, c);
    tick(3);
    strum_pulse();
    tick(6);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_miss"}, miss, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_streak"}, streak, 0);
    chk({tag, "_mult"}, mult, 1);
    chk({tag, "_chord"}, cur_chord, 0);
  endtask
  initial begin
    logic [4:0] c;
    int gap, sp;
    bit do_strum;
    tick(2);
    chk_reset("por");
    resetn = 1'b1;
    tick(2);
    beat(5'b00101, 5'b00101);
    tick(5);
    strum_pulse();
    tick(6);
    chk("hit1_score", score, 10);
    chk("hit1_streak", streak, 1);
    chk("hit1_mult", mult, 1);
    repeat (2) hit_seq(5'b10001);
    chk("hit3_score", score, 40);
    chk("hit3_streak", streak, 3);
    chk("hit3_mult", mult, 2);
    hit_seq(5'b01100);
    chk("hit4_score", score, 60);
    chk("hit4_mult", mult, 3);
    beat(5'b01010, 5'b01110);
    tick(3);
    strum_pulse();
    tick(6);
    chk("wrong_score", score, 60);
    chk("wrong_streak", streak, 0);
    chk("wrong_mult", mult, 1);
    hit_seq(5'b00011);
    beat(5'b10100, 5'b10100);
    tick(30);
    chk("expire_streak", streak, 0);
    beat(5'b00111, 5'b00111);
    tick(4);
    chk("open_chord", cur_chord, 5'b00111);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1 chk_reset("async");
    @(negedge clk);
    resetn = 1'b1;
    tick(2);
    hit_seq(5'b00111);
    beat(5'b00000, 5'b00000);
    tick(4);
    strum_pulse();
    tick(4);
    chk("rest_streak", streak, 0);
    beat(5'b11000, 5'b11000);
    tick(19);
    strum_pulse();
    tick(6);
    chk("tie_hit_streak", streak, 1);
    beat(5'b11000, 5'b00011);
    tick(19);
    strum_pulse();
    tick(6);
    chk("tie_miss_streak", streak, 0);
    for (int i = 0; i < 300; i++) begin
      c = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      beat(c, ($urandom % 3 == 0) ? 5'($urandom) : c);
      gap = $urandom_range(0, 40);
      sp = $urandom_range(0, gap);
      do_strum = $urandom % 4 != 0;
      for (int k = 0; k < gap; k++) begin
        strum = do_strum && k >= sp && k < sp + 2;
        @(negedge clk);
      end
      strum = 1'b0;
      @(negedge clk);
    end
    tick(30);
    for (int i = 0; i < 260; i++) begin
      c = 5'($urandom_range(1, 31));
      beat(c, c);
      tick(1);
      strum_pulse();
      tick(2);
    end
    tick(4);
    chk("sat_streak", streak, 255);
    chk("sat_mult", mult, MAXM);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
